// File: rtl/div_sched_if.sv
// Request/grant/result bundle between the two requesters and the shared divider.
interface div_sched_if;
  logic       req0;
  logic [7:0] a0;
  logic [7:0] b0;
  logic       req1;
  logic [7:0] a1;
  logic [7:0] b1;
  logic       gnt0;
  logic       gnt1;
  logic       done0;
  logic       done1;
  logic [7:0] q;
  logic [7:0] r;
  logic       dz;
  logic       busy;

  modport master (
    output req0, a0, b0, req1, a1, b1,
    input  gnt0, gnt1, done0, done1, q, r, dz, busy
  );

  modport slave (
    input  req0, a0, b0, req1, a1, b1,
    output gnt0, gnt1, done0, done1, q, r, dz, busy
  );
endinterface

// File: rtl/div_sched.sv
// Two-requester 8-bit restoring divider, round-robin ownership, falling-edge state.
// Latency 10 cycles from the sampling edge (2 for a zero divisor); non-owner waits for IDLE.
module div_sched (
  input logic        clk,
  input logic        rst,
  div_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       owner_q, owner_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] rem_q, rem_d;
  logic [7:0] quo_q, quo_d;
  logic [7:0] qo_q, qo_d;
  logic [7:0] ro_q, ro_d;
  logic       dz_q, dz_d;

  logic       sel;
  logic [8:0] shifted;
  logic       ge;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    qo_d    = qo_q;
    ro_d    = ro_q;
    dz_d    = dz_q;

    // With both requesting, the one not served last wins.
    if (bus.req0 && bus.req1) sel = ~last_q;
    else                      sel = bus.req1;

    shifted = {rem_q, quo_q[7]};
    ge      = (shifted >= {1'b0, b_q});

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_d = LOAD;
          owner_d = sel;
          last_d  = sel;
          a_d     = sel ? bus.a1 : bus.a0;
          b_d     = sel ? bus.b1 : bus.b0;
        end
      end
      LOAD: begin
        if (b_q == 8'd0) begin
          state_d = DONE;
          qo_d    = 8'hFF;
          ro_d    = a_q;
          dz_d    = 1'b1;
        end else begin
          rem_d   = 8'd0;
          quo_d   = a_q;
          cnt_d   = 3'd7;
          state_d = ITER;
        end
      end
      ITER: begin
        rem_d = ge ? 8'(shifted - {1'b0, b_q}) : shifted[7:0];
        quo_d = {quo_q[6:0], ge};
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          qo_d    = {quo_q[6:0], ge};
          ro_d    = ge ? 8'(shifted - {1'b0, b_q}) : shifted[7:0];
          dz_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      last_q  <= 1'b1;
      owner_q <= 1'b0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      rem_q   <= 8'd0;
      quo_q   <= 8'd0;
      qo_q    <= 8'd0;
      ro_q    <= 8'd0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      qo_q    <= qo_d;
      ro_q    <= ro_d;
      dz_q    <= dz_d;
    end
  end

  assign bus.busy  = (state_q != IDLE);
  assign bus.gnt0  = (state_q != IDLE) && !owner_q;
  assign bus.gnt1  = (state_q != IDLE) &&  owner_q;
  assign bus.done0 = (state_q == DONE) && !owner_q;
  assign bus.done1 = (state_q == DONE) &&  owner_q;
  assign bus.q     = qo_q;
  assign bus.r     = ro_q;
  assign bus.dz    = dz_q;
endmodule

// File: tb/tb_div_sched.sv
// Directed and randomized stimulus for div_sched against an arithmetic reference model.
module tb_div_sched;
  logic clk = 1'b0;
  logic rst = 1'b0;

  div_sched_if bus();

  div_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit       last_srv = 1'b1;
  logic [7:0] pq = 8'd0;
  logic [7:0] pr = 8'd0;
  logic       pdz = 1'b0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic ref_div(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] eq, output logic [7:0] er, output logic edz);
    if (b == 8'd0) begin
      eq = 8'hFF; er = a; edz = 1'b1;
    end else begin
      eq = a / b; er = a % b; edz = 1'b0;
    end
  endtask

  task automatic set_req(input bit who, input bit v, input logic [7:0] a, input logic [7:0] b);
    if (who) begin bus.req1 = v; bus.a1 = a; bus.b1 = b; end
    else     begin bus.req0 = v; bus.a0 = a; bus.b0 = b; end
  endtask

  task automatic single_op(input bit who, input logic [7:0] a, input logic [7:0] b,
                           input bit perturb, input bit drop);
    logic [7:0] eq, er;
    logic       edz;
    bit         seen;
    int         explat;
    @(posedge clk);
    chk("idle_busy", 16'(bus.busy), 0);
    chk("hold_q", 16'(bus.q), 16'(pq));
    chk("hold_r", 16'(bus.r), 16'(pr));
    chk("hold_dz", 16'(bus.dz), 16'(pdz));
    set_req(who, 1'b1, a, b);
    ref_div(a, b, eq, er, edz);
    explat = (b == 8'd0) ? 2 : 10;
    seen = 1'b0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      @(posedge clk);
      chk("gnt_owner", 16'(who ? bus.gnt1 : bus.gnt0), 1);
      chk("gnt_other", 16'(who ? bus.gnt0 : bus.gnt1), 0);
      if (n == 1 && perturb) set_req(who, 1'b1, 8'($urandom), 8'($urandom));
      if (n == 3 && drop) begin
        if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      end
      if (bus.done0 || bus.done1) begin
        seen = 1'b1;
        chk("done_owner", 16'(who ? bus.done1 : bus.done0), 1);
        chk("done_other", 16'(who ? bus.done0 : bus.done1), 0);
        chk("latency", 16'(n), 16'(explat));
        chk("q", 16'(bus.q), 16'(eq));
        chk("r", 16'(bus.r), 16'(er));
        chk("dz", 16'(bus.dz), 16'(edz));
        if (who) bus.req1 = 1'b0; else bus.req0 = 1'b0;
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    pq = eq; pr = er; pdz = edz;
    last_srv = who;
  endtask

  task automatic concurrent(input int nops);
    logic [7:0] oa [2];
    logic [7:0] ob [2];
    logic [7:0] eq, er;
    logic       edz;
    bit exp_w, cur, pg0, pg1;
    int done_cnt, grant_cnt, rise;
    exp_w = ~last_srv;
    done_cnt = 0; grant_cnt = 0; rise = 0; pg0 = 0; pg1 = 0;
    oa[0] = 8'd255; ob[0] = 8'd1;
    oa[1] = 8'd5;   ob[1] = 8'd9;
    @(posedge clk);
    set_req(1'b0, 1'b1, oa[0], ob[0]);
    set_req(1'b1, 1'b1, oa[1], ob[1]);
    for (int n = 1; n <= nops * 12 + 10 && done_cnt < nops; n++) begin
      @(posedge clk);
      chk("gnt_excl", 16'(bus.gnt0 & bus.gnt1), 0);
      chk("done_excl", 16'(bus.done0 & bus.done1), 0);
      if ((bus.gnt0 && !pg0) || (bus.gnt1 && !pg1)) begin
        cur = bus.gnt1;
        chk("grant_order", 16'(cur), 16'(exp_w));
        chk("grant_after_done", 16'(grant_cnt), 16'(done_cnt));
        grant_cnt++;
        rise = n;
      end
      pg0 = bus.gnt0; pg1 = bus.gnt1;
      if (bus.done0 || bus.done1) begin
        cur = bus.done1;
        chk("done_who", 16'(cur), 16'(exp_w));
        ref_div(oa[exp_w], ob[exp_w], eq, er, edz);
        chk("conc_q", 16'(bus.q), 16'(eq));
        chk("conc_r", 16'(bus.r), 16'(er));
        chk("conc_dz", 16'(bus.dz), 16'(edz));
        chk("conc_latency", 16'(n - rise + 1), (ob[exp_w] == 8'd0) ? 16'd2 : 16'd10);
        pq = eq; pr = er; pdz = edz;
        done_cnt++;
        last_srv = exp_w;
        if (done_cnt == nops) begin
          bus.req0 = 1'b0; bus.req1 = 1'b0;
        end else begin
          oa[exp_w] = 8'($urandom);
          ob[exp_w] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
          set_req(exp_w, 1'b1, oa[exp_w], ob[exp_w]);
        end
        exp_w = ~exp_w;
      end
    end
    if (done_cnt != nops) chk("conc_timeout", 16'(done_cnt), 16'(nops));
  endtask

  task automatic reset_mid();
    @(posedge clk);
    set_req(1'b0, 1'b1, 8'($urandom), 8'($urandom_range(1, 255)));
    for (int n = 1; n <= 5; n++) @(posedge clk);
    chk("mid_busy", 16'(bus.busy), 1);
    rst = 1'b0;
    #1;
    chk("arst_gnt0", 16'(bus.gnt0), 0);
    chk("arst_gnt1", 16'(bus.gnt1), 0);
    chk("arst_done", 16'(bus.done0 | bus.done1), 0);
    chk("arst_busy", 16'(bus.busy), 0);
    chk("arst_q", 16'(bus.q), 0);
    chk("arst_r", 16'(bus.r), 0);
    chk("arst_dz", 16'(bus.dz), 0);
    bus.req0 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      chk("rst_no_done", 16'(bus.done0 | bus.done1), 0);
    end
    rst = 1'b1;
    pq = 8'd0; pr = 8'd0; pdz = 1'b0; last_srv = 1'b1;
    repeat (12) begin
      @(posedge clk);
      chk("post_rst_no_done", 16'(bus.done0 | bus.done1), 0);
      chk("post_rst_idle", 16'(bus.busy), 0);
    end
    single_op(1'b0, 8'd9, 8'd3, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req0 = 1'b0; bus.a0 = 8'd0; bus.b0 = 8'd0;
    bus.req1 = 1'b0; bus.a1 = 8'd0; bus.b1 = 8'd0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    chk("rst_gnt0", 16'(bus.gnt0), 0);
    chk("rst_gnt1", 16'(bus.gnt1), 0);
    chk("rst_done0", 16'(bus.done0), 0);
    chk("rst_done1", 16'(bus.done1), 0);
    chk("rst_busy", 16'(bus.busy), 0);
    chk("rst_q", 16'(bus.q), 0);
    chk("rst_r", 16'(bus.r), 0);
    chk("rst_dz", 16'(bus.dz), 0);
    rst = 1'b1;

    single_op(1'b0, 8'd100, 8'd7, 1'b0, 1'b0);
    single_op(1'b1, 8'd200, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      single_op(1'($urandom), 8'($urandom),
                ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
                1'($urandom), 1'($urandom));
    end

    @(posedge clk);
    rst = 1'b0;
    @(posedge clk);
    rst = 1'b1;
    last_srv = 1'b1; pq = 8'd0; pr = 8'd0; pdz = 1'b0;
    concurrent(6);

    reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its falling edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port req0, input, 1 bit: requester 0 division request, level-held until done0.
REQ-004 SHALL have port a0, input, 8 bits: requester 0 dividend (unsigned).
REQ-005 SHALL have port b0, input, 8 bits: requester 0 divisor (unsigned).
REQ-006 SHALL have ports req1, a1 and b1, with the same directions and widths as req0/a0/b0: requester 1 request, dividend and divisor.
REQ-007 SHALL have ports gnt0 and gnt1, outputs, 1 bit each: requester owns the divider, from LOAD through DONE inclusive.
REQ-008 SHALL have ports done0 and done1, outputs, 1 bit each: one-cycle result-valid pulse to the owning requester.
REQ-009 SHALL have port q, output, 8 bits: quotient of the last completed operation.
REQ-010 SHALL have port r, output, 8 bits: remainder of the last completed operation.
REQ-011 SHALL have port dz, output, 1 bit: last completed operation had divisor zero.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, LOAD, ITER and DONE, with an internal 3-bit iteration counter cnt.
REQ-014 IDLE: on a falling edge with req0 or req1 high, SHALL go to LOAD, latch the selected requester's a/b, set the owner and assert its gnt; with no request, SHALL remain in IDLE.
REQ-015 Arbitration SHALL be round-robin on a last-served pointer: with both requests high, the requester not served last wins; the pointer's reset value favours requester 0.
REQ-016 LOAD, when divisor is nonzero: SHALL clear the remainder register, load the dividend into the quotient shift register, set cnt=7 and go to ITER.
REQ-017 LOAD, when divisor == 0: SHALL go directly to DONE with q=8'hFF, r=dividend and dz=1.
REQ-018 ITER, every cycle, restoring step: shift {rem,quo} left 1; trial = rem - divisor (9-bit); if trial is non-negative, rem=trial and the new quo LSB=1, else rem is unchanged and the new quo LSB=0.
REQ-019 ITER SHALL run exactly 8 cycles, decrementing cnt, and SHALL go to DONE after the cycle with cnt==0.
REQ-020 DONE: SHALL update q/r/dz from the internal registers, pulse the owner's done for exactly one cycle, clear gnt and return to IDLE.
REQ-021 q, r and dz SHALL hold their values until the next DONE.
REQ-022 Latency, nonzero divisor: done SHALL be high during the 10th cycle after the edge that sampled req (1 LOAD + 8 ITER + 1 DONE).
REQ-023 Latency, divisor zero: done SHALL be high in the 2nd cycle after the sampling edge.
REQ-024 Operands SHALL be captured only in LOAD; a/b changes after LOAD SHALL have no effect on the operation in progress.
REQ-025 A request deasserted mid-operation SHALL NOT abort it: the operation completes and done still pulses.
REQ-026 A request from the non-owner during LOAD/ITER/DONE SHALL be ignored until IDLE.
REQ-027 At most one of gnt0/gnt1 and at most one of done0/done1 SHALL be high in any cycle.
REQ-028 A requester still holding req in the IDLE cycle after its done SHALL be re-arbitrated as a new request, subject to round-robin.

Reset
REQ-029 rst low SHALL immediately, without waiting for clk, force: state IDLE; cnt 0; pointer to favour req0; gnt0, gnt1, done0, done1, busy, dz at 0; q, r and internal registers at 0.
REQ-030 rst asserted mid-operation SHALL discard that operation with no done pulse; after release, the state machine restarts from IDLE.

Verification
REQ-031 req0, a0=100, b0=7 -> gnt0 during LOAD..DONE; done0 in the 10th cycle after the sampling edge; q=14, r=2, dz=0.
REQ-032 After reset, req0 and req1 rise together (a0=255/b0=1, a1=5/b1=9) -> requester 0 first: q=255, r=0; then requester 1: q=0, r=5; gnt never overlaps.
REQ-033 req1, a1=200, b1=0 -> done1 in the 2nd cycle after the sampling edge; q=8'hFF, r=200, dz=1.
REQ-034 Both requesters hold req continuously for 4 operations -> grants alternate 0,1,0,1, each done precedes the next grant.
REQ-035 rst pulled low during the 4th ITER cycle -> all outputs 0 asynchronously, no done pulse; a fresh req0 of 9/3 afterwards -> q=3, r=0.
